dbus_arbiter: RTL and testbench
===============================

Name: dbus_arbiter

Overview:
- Two-master round-robin arbiter for the shared register data bus (Addr/Dout/Din/Wr).
- Sits between two bus masters (e.g. a testbench master model and a control FSM) and the single register-bank slave.
- Grants exclusive bus ownership through a Req/Gnt handshake and muxes the owner's address, data and write strobe onto the bus.
- Enforces a maximum hold time so one master cannot starve the other.

Parameters:
- DATA_WIDTH, 8, bus data size
- ADDR_WIDTH, 3, bus address size
- MAX_HOLD, 8, max consecutive granted cycles while the other master waits; 0 = unlimited

Ports:
- Clk  input  1  system clock
- Rst  input  1  reset
- M0_Req  input  1  master 0 requests bus ownership
- M0_Gnt  output  1  master 0 owns bus
- M0_Addr  input  ADDR_WIDTH  master 0 address
- M0_Dout  input  DATA_WIDTH  master 0 write data
- M0_Wr  input  1  master 0 write enable
- M0_Din  output  DATA_WIDTH  read data to master 0
- M1_Req, M1_Gnt, M1_Addr, M1_Dout, M1_Wr, M1_Din: same as M0_* for master 1
- Addr  output  ADDR_WIDTH  bus address
- Dout  output  DATA_WIDTH  bus write data
- Din  input  DATA_WIDTH  bus read data from slave
- Wr  output  1  bus write enable

Interface: one clock; reset is synchronous and active-high.

Behaviour:
- **State machine.** States are IDLE, OWN0 and OWN1. M0_Gnt = (state==OWN0) and M1_Gnt = (state==OWN1), both decoded from registered state.
- **Reset.** Synchronous Rst forces:
  - state=IDLE, hold counter=0, Last=1 (so M0 wins the first tie).
  - Gnt=0 and bus Addr/Dout/Wr=0 in the cycle after the reset edge.
  - Reset mid-ownership drops Gnt at that edge with no grace cycle.
- **IDLE:**
  - Only M0_Req → OWN0. Only M1_Req → OWN1.
  - Both requesting → grant the master ≠ Last.
  - Latency: Req seen at edge N gives Gnt high after edge N (one cycle).
- **OWNx:**
  - Mx_Req=0 → switch to other master if it requests, else IDLE. No dead cycle on handover.
  - Hold counter increments each owned cycle while the other Req=1 and resets to 0 when the other Req=0.
  - When counter reaches MAX_HOLD-1 with the other requesting → force switch to the other master (pre-emption); counter clears.
  - MAX_HOLD=0 disables pre-emption.
  - Last is updated to x on every entry into OWNx.
- **Bus mux (combinational from state):**
  - OWN0 → Addr=M0_Addr, Dout=M0_Dout, Wr=M0_Wr.
  - OWN1 → the same from M1.
  - IDLE → all zero.
  - Wr from a non-granted master is never propagated.
- **Read data.** Din is broadcast unregistered to both M0_Din and M1_Din. Masters must qualify it with their own Gnt.
- **Master rules.**
  - A master keeps Req high for its entire access sequence.
  - A master may drive Wr only while Gnt=1.
  - Dropping Req releases the bus at the next edge. A Wr asserted in the same cycle as the Req drop is still propagated, since Gnt is still high that cycle.
- **Pre-emption.** When pre-empted, a master sees Gnt fall while Req is still high. It must stall and re-arbitrate (its Req stays high and it regains the bus by round-robin).
- **Hold counter width.** $clog2(MAX_HOLD+1), minimum 1. It must not wrap.

Test Plan:
1. **Reset defaults.** Assert Rst 2 cycles with both Req=1 → M0_Gnt=M1_Gnt=0, Addr=0, Dout=0, Wr=0. After release, M0_Gnt=1 one cycle later (tie, Last=1).
2. **Single write through M0.** M0_Req=1, then after Gnt M0 drives Addr=3'h5, Dout=8'hA5, Wr=1 for one cycle → bus shows 5/A5/Wr=1 that cycle. M1 driving Wr=1, Addr=2 meanwhile never reaches the bus.
3. **Round-robin tie.** Both Req held; M0 owns, M0 drops Req → M1_Gnt=1 on the very next cycle with no IDLE. Re-raise M0_Req with M1 dropping → M0 regains.
4. **Pre-emption.** MAX_HOLD=8; M0 owns and holds Req, M1_Req raised at cycle k → M0_Gnt falls and M1_Gnt rises after exactly 8 M1-waiting cycles. With MAX_HOLD=0, M0 keeps the bus for 50 cycles.
5. **Read path.** M1 owns, Addr=3'h2, slave Din=8'h3C → M1_Din=8'h3C the same cycle. M0_Din also shows 3C but M0_Gnt=0.
6. **Reset mid-ownership.** Rst pulsed while OWN1 and M1_Wr=1 → next cycle Wr=0 and M1_Gnt=0. After release with only M1_Req → M1_Gnt=1 one cycle later.

Source files
------------

// File: rtl/dbus_arbiter.sv
// Two-master round-robin arbiter for the shared register data bus.
// Grants ownership via Req/Gnt, muxes the owner onto the bus and bounds hold time.
module dbus_arbiter #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned MAX_HOLD   = 8
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  M0_Req,
    output logic                  M0_Gnt,
    input  logic [ADDR_WIDTH-1:0] M0_Addr,
    input  logic [DATA_WIDTH-1:0] M0_Dout,
    input  logic                  M0_Wr,
    output logic [DATA_WIDTH-1:0] M0_Din,
    input  logic                  M1_Req,
    output logic                  M1_Gnt,
    input  logic [ADDR_WIDTH-1:0] M1_Addr,
    input  logic [DATA_WIDTH-1:0] M1_Dout,
    input  logic                  M1_Wr,
    output logic [DATA_WIDTH-1:0] M1_Din,
    output logic [ADDR_WIDTH-1:0] Addr,
    output logic [DATA_WIDTH-1:0] Dout,
    input  logic [DATA_WIDTH-1:0] Din,
    output logic                  Wr
);

    localparam int unsigned CNT_BITS = $clog2(MAX_HOLD + 1);
    localparam int unsigned CNT_W    = (CNT_BITS < 1) ? 1 : CNT_BITS;
    localparam int unsigned LIMIT    = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t           state;
    logic             last;
    logic [CNT_W-1:0] hold_cnt;

    logic own_req;
    logic other_req;
    logic hold_expired;

    // Requests seen from the current owner's point of view.
    always_comb begin
        own_req   = 1'b0;
        other_req = 1'b0;
        case (state)
            OWN0: begin
                own_req   = M0_Req;
                other_req = M1_Req;
            end
            OWN1: begin
                own_req   = M1_Req;
                other_req = M0_Req;
            end
            default: begin
                own_req   = 1'b0;
                other_req = 1'b0;
            end
        endcase
    end

    assign hold_expired = (MAX_HOLD != 0) && (hold_cnt == CNT_LIMIT);

    // Ownership FSM; last remembers the most recent owner for tie-breaks.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state    <= IDLE;
            last     <= 1'b1;
            hold_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    hold_cnt <= '0;
                    if (M0_Req && (!M1_Req || last)) begin
                        state <= OWN0;
                        last  <= 1'b0;
                    end else if (M1_Req) begin
                        state <= OWN1;
                        last  <= 1'b1;
                    end
                end
                OWN0, OWN1: begin
                    if (!own_req || (other_req && hold_expired)) begin
                        hold_cnt <= '0;
                        if (other_req) begin
                            state <= (state == OWN0) ? OWN1 : OWN0;
                            last  <= (state == OWN0);
                        end else begin
                            state <= IDLE;
                        end
                    end else if (!other_req) begin
                        hold_cnt <= '0;
                    end else if (hold_cnt != CNT_MAX) begin
                        // Saturate so an unlimited hold never wraps.
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    hold_cnt <= '0;
                end
            endcase
        end
    end

    assign M0_Gnt = (state == OWN0);
    assign M1_Gnt = (state == OWN1);

    // Only the owner reaches the bus; idle drives zeros.
    always_comb begin
        Addr = '0;
        Dout = '0;
        Wr   = 1'b0;
        case (state)
            OWN0: begin
                Addr = M0_Addr;
                Dout = M0_Dout;
                Wr   = M0_Wr;
            end
            OWN1: begin
                Addr = M1_Addr;
                Dout = M1_Dout;
                Wr   = M1_Wr;
            end
            default: begin
                Addr = '0;
                Dout = '0;
                Wr   = 1'b0;
            end
        endcase
    end

    assign M0_Din = Din;
    assign M1_Din = Din;

endmodule

// File: tb/tb_dbus_arbiter.sv
// Bench for dbus_arbiter: directed vector table, pre-emption sequences and
// randomized traffic against an ownership model, on MAX_HOLD=8 and MAX_HOLD=0.
module tb_dbus_arbiter;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 3;
    localparam int unsigned OW = 2 + AW + DW + 1 + 2 * DW;

    typedef logic [OW-1:0] obs_t;

    typedef struct {
        logic          rst, r0, r1;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        logic          w0;
        logic [AW-1:0] a1;
        logic [DW-1:0] d1;
        logic          w1;
        logic [DW-1:0] din;
        logic          chk;
        logic          eg0, eg1;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic          ew;
    } vec_t;

    logic          Clk = 1'b0;
    logic          Rst;
    logic          M0_Req, M1_Req, M0_Wr, M1_Wr;
    logic [AW-1:0] M0_Addr, M1_Addr;
    logic [DW-1:0] M0_Dout, M1_Dout, Din;

    logic          m0_gnt [2];
    logic          m1_gnt [2];
    logic          wr_o   [2];
    logic [AW-1:0] addr_o [2];
    logic [DW-1:0] dout_o [2];
    logic [DW-1:0] m0_din [2];
    logic [DW-1:0] m1_din [2];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Behavioural ownership model per instance: -1 idle, else owning master.
    int  own_m   [2];
    int  last_m  [2];
    int  wait_m  [2];
    int  maxh_m  [2];
    bit  model_valid = 1'b0;

    always #5 Clk = ~Clk;

    dbus_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_HOLD(8)) u_dut8 (
        .Clk(Clk), .Rst(Rst),
        .M0_Req(M0_Req), .M0_Gnt(m0_gnt[0]), .M0_Addr(M0_Addr), .M0_Dout(M0_Dout),
        .M0_Wr(M0_Wr), .M0_Din(m0_din[0]),
        .M1_Req(M1_Req), .M1_Gnt(m1_gnt[0]), .M1_Addr(M1_Addr), .M1_Dout(M1_Dout),
        .M1_Wr(M1_Wr), .M1_Din(m1_din[0]),
        .Addr(addr_o[0]), .Dout(dout_o[0]), .Din(Din), .Wr(wr_o[0])
    );

    dbus_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_HOLD(0)) u_dut0 (
        .Clk(Clk), .Rst(Rst),
        .M0_Req(M0_Req), .M0_Gnt(m0_gnt[1]), .M0_Addr(M0_Addr), .M0_Dout(M0_Dout),
        .M0_Wr(M0_Wr), .M0_Din(m0_din[1]),
        .M1_Req(M1_Req), .M1_Gnt(m1_gnt[1]), .M1_Addr(M1_Addr), .M1_Dout(M1_Dout),
        .M1_Wr(M1_Wr), .M1_Din(m1_din[1]),
        .Addr(addr_o[1]), .Dout(dout_o[1]), .Din(Din), .Wr(wr_o[1])
    );

    function automatic obs_t dut_obs(int k);
        return {m0_gnt[k], m1_gnt[k], addr_o[k], dout_o[k], wr_o[k], m0_din[k], m1_din[k]};
    endfunction

    function automatic obs_t model_obs(int k);
        logic          g0, g1, w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        g0 = (own_m[k] == 0);
        g1 = (own_m[k] == 1);
        a  = g0 ? M0_Addr : (g1 ? M1_Addr : '0);
        d  = g0 ? M0_Dout : (g1 ? M1_Dout : '0);
        w  = g0 ? M0_Wr   : (g1 ? M1_Wr   : 1'b0);
        return {g0, g1, a, d, w, Din, Din};
    endfunction

    task automatic model_step(int k);
        int r [2];
        int m, o;
        r[0] = int'(M0_Req);
        r[1] = int'(M1_Req);
        if (Rst) begin
            own_m[k]  = -1;
            last_m[k] = 1;
            wait_m[k] = 0;
        end else if (own_m[k] < 0) begin
            wait_m[k] = 0;
            if (r[0] != 0 && r[1] != 0) own_m[k] = 1 - last_m[k];
            else if (r[0] != 0)         own_m[k] = 0;
            else if (r[1] != 0)         own_m[k] = 1;
            if (own_m[k] >= 0) last_m[k] = own_m[k];
        end else begin
            m = own_m[k];
            o = 1 - m;
            if (r[m] == 0) begin
                wait_m[k] = 0;
                own_m[k]  = (r[o] != 0) ? o : -1;
                if (own_m[k] >= 0) last_m[k] = own_m[k];
            end else if (r[o] != 0) begin
                // Count edges the other master has waited; hand over on the MAX_HOLD-th.
                wait_m[k] = wait_m[k] + 1;
                if (maxh_m[k] != 0 && wait_m[k] >= maxh_m[k]) begin
                    own_m[k]  = o;
                    last_m[k] = o;
                    wait_m[k] = 0;
                end
            end else begin
                wait_m[k] = 0;
            end
        end
    endtask

    task automatic check_obs(string name, obs_t got, obs_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    task automatic check_int(string name, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0d exp=%0d", name, cyc, got, exp);
        end
    endtask

    // Mid-cycle: compare both instances against the model.
    task automatic settle();
        @(negedge Clk);
        if (model_valid) begin
            check_obs("model_hold8", dut_obs(0), model_obs(0));
            check_obs("model_hold0", dut_obs(1), model_obs(1));
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        model_step(0);
        model_step(1);
        if (Rst) model_valid = 1'b1;
        cyc++;
        #1;
    endtask

    function automatic vec_t row(bit rst, bit r0, bit r1, int a0, int d0, bit w0,
                                 int a1, int d1, bit w1, int din, bit chk,
                                 bit eg0, bit eg1, int ea, int ed, bit ew);
        vec_t v;
        v.rst = rst; v.r0 = r0; v.r1 = r1;
        v.a0 = AW'(a0); v.d0 = DW'(d0); v.w0 = w0;
        v.a1 = AW'(a1); v.d1 = DW'(d1); v.w1 = w1;
        v.din = DW'(din); v.chk = chk;
        v.eg0 = eg0; v.eg1 = eg1; v.ea = AW'(ea); v.ed = DW'(ed); v.ew = ew;
        return v;
    endfunction

    task automatic drive(logic rst, logic r0, logic r1);
        Rst    = rst;
        M0_Req = r0;
        M1_Req = r1;
    endtask

    vec_t tbl [16];

    initial begin
        #1_000_000;
        $display("FAIL timeout cycle=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int waited;
        bit got_gnt;
        obs_t exp;

        maxh_m[0] = 8;
        maxh_m[1] = 0;
        for (int k = 0; k < 2; k++) begin
            own_m[k] = -1; last_m[k] = 1; wait_m[k] = 0;
        end

        Rst = 1'b1; M0_Req = 1'b0; M1_Req = 1'b0; M0_Wr = 1'b0; M1_Wr = 1'b0;
        M0_Addr = '0; M1_Addr = '0; M0_Dout = '0; M1_Dout = '0; Din = '0;

        //          rst r0 r1  a0 d0    w0  a1 d1    w1  din   chk g0 g1 ea ed    ew
        tbl[0]  = row(1, 1, 1, 7, 8'hFF, 0, 2, 8'h77, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0);
        tbl[1]  = row(1, 1, 1, 7, 8'hFF, 0, 2, 8'h77, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0);
        tbl[2]  = row(0, 1, 1, 7, 8'hFF, 0, 2, 8'h77, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0);
        tbl[3]  = row(0, 1, 0, 5, 8'hA5, 1, 2, 8'h77, 1, 8'h00, 1, 1, 0, 5, 8'hA5, 1);
        tbl[4]  = row(0, 1, 0, 5, 8'hA5, 0, 2, 8'h77, 1, 8'h00, 1, 1, 0, 5, 8'hA5, 0);
        tbl[5]  = row(0, 1, 1, 1, 8'h11, 0, 2, 8'h77, 0, 8'h00, 1, 1, 0, 1, 8'h11, 0);
        tbl[6]  = row(0, 0, 1, 1, 8'h11, 1, 2, 8'h77, 0, 8'h00, 1, 1, 0, 1, 8'h11, 1);
        tbl[7]  = row(0, 1, 0, 1, 8'h11, 0, 2, 8'h22, 0, 8'h00, 1, 0, 1, 2, 8'h22, 0);
        tbl[8]  = row(0, 1, 0, 3, 8'h33, 0, 2, 8'h22, 0, 8'h00, 1, 1, 0, 3, 8'h33, 0);
        tbl[9]  = row(0, 0, 1, 3, 8'h33, 0, 2, 8'h22, 0, 8'h00, 1, 1, 0, 3, 8'h33, 0);
        tbl[10] = row(0, 0, 1, 3, 8'h33, 0, 2, 8'hD2, 0, 8'h3C, 1, 0, 1, 2, 8'hD2, 0);
        tbl[11] = row(1, 0, 1, 3, 8'h33, 0, 6, 8'h5A, 1, 8'h3C, 1, 0, 1, 6, 8'h5A, 1);
        tbl[12] = row(0, 0, 1, 3, 8'h33, 0, 6, 8'h5A, 1, 8'h00, 1, 0, 0, 0, 8'h00, 0);
        tbl[13] = row(0, 0, 1, 3, 8'h33, 0, 4, 8'h44, 0, 8'h00, 1, 0, 1, 4, 8'h44, 0);
        tbl[14] = row(0, 0, 0, 3, 8'h33, 0, 4, 8'h44, 0, 8'h00, 1, 0, 1, 4, 8'h44, 0);
        tbl[15] = row(0, 0, 0, 3, 8'h33, 0, 4, 8'h44, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0);

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].rst, tbl[i].r0, tbl[i].r1);
            M0_Addr = tbl[i].a0; M0_Dout = tbl[i].d0; M0_Wr = tbl[i].w0;
            M1_Addr = tbl[i].a1; M1_Dout = tbl[i].d1; M1_Wr = tbl[i].w1;
            Din     = tbl[i].din;
            settle();
            if (tbl[i].chk) begin
                exp = {tbl[i].eg0, tbl[i].eg1, tbl[i].ea, tbl[i].ed, tbl[i].ew,
                       tbl[i].din, tbl[i].din};
                check_obs($sformatf("vector_%0d", i), dut_obs(0), exp);
            end
            tick();
        end

        // Pre-emption: M0 owns, M1 starts waiting; handover after exactly 8 waits.
        M0_Wr = 1'b0; M1_Wr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 0);
            settle();
            tick();
        end
        check_int("m0_owns_before_wait", int'(m0_gnt[0]), 1);
        waited  = 0;
        got_gnt = 1'b0;
        while (waited < 20 && !got_gnt) begin
            drive(0, 1, 1);
            settle();
            tick();
            waited++;
            if (m1_gnt[0]) got_gnt = 1'b1;
        end
        check_int("preempt_wait_cycles", waited, 8);
        check_int("preempt_m0_gnt_low", int'(m0_gnt[0]), 0);
        for (int i = 0; i < 42; i++) begin
            drive(0, 1, 1);
            settle();
            tick();
        end
        check_int("unlimited_hold_50", int'(m0_gnt[1]), 1);
        check_int("unlimited_hold_m1_low", int'(m1_gnt[1]), 0);

        // Randomized traffic with sticky requests so long holds occur.
        drive(0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            Rst = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 7) == 0) M0_Req = ~M0_Req;
            if ($urandom_range(0, 7) == 0) M1_Req = ~M1_Req;
            M0_Addr = AW'($urandom); M0_Dout = DW'($urandom); M0_Wr = 1'($urandom);
            M1_Addr = AW'($urandom); M1_Dout = DW'($urandom); M1_Wr = 1'($urandom);
            Din     = DW'($urandom);
            settle();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
